ram_dp_fifo_ctrl: RTL and testbench
===================================

RAM_DP_FIFO_CTRL -- requirements
Module: ram_dp_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, which sets the stream and RAM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, which sets the RAM address width; DEPTH = 1 << ADDR_WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_data, input, DATA_WIDTH: write-stream data.
REQ-006 SHALL have ports s_valid (input, 1) and s_ready (output, 1): write-stream handshake.
REQ-007 SHALL have port m_data, output, DATA_WIDTH: read-stream data, registered.
REQ-008 SHALL have ports m_valid (output, 1) and m_ready (input, 1): read-stream handshake.
REQ-009 SHALL have port level, output, ADDR_WIDTH+1: entries held in RAM, including the entry being fetched.
REQ-010 SHALL have ports full and empty, output, 1 bit each: status flags.
REQ-011 SHALL have ports address_0 (output, ADDR_WIDTH), cs_0, we_0 and oe_0 (outputs, 1 bit each), and wdata_0 (output, DATA_WIDTH, tied to the RAM data_0 bus): RAM write port.
REQ-012 SHALL have ports address_1 (output, ADDR_WIDTH), cs_1, we_1 and oe_1 (outputs, 1 bit each), and data_1 (input, DATA_WIDTH): RAM read port.

Function
REQ-013 SHALL accept a write when s_valid && s_ready at a rising edge.
REQ-014 SHALL drive s_ready = !full.
REQ-015 SHALL drive cs_0 = we_0 = (s_valid && s_ready) combinationally.
REQ-016 SHALL drive address_0 = wr_ptr and wdata_0 = s_data combinationally, so the RAM writes on the same edge as the accept.
REQ-017 SHALL hold oe_0 = 0 and we_1 = 0 constantly; the RAM therefore never drives data_0.
REQ-018 SHALL increment wr_ptr (ADDR_WIDTH bits) on each accepted write, wrapping from DEPTH-1 to 0.
REQ-019 SHALL implement a read FSM with states R_IDLE, R_FETCH and R_CAPTURE.
REQ-020 SHALL move R_IDLE -> R_FETCH when level != 0 && m_valid == 0, using registered values.
REQ-021 SHALL, in R_FETCH: cs_1 = oe_1 = 1, address_1 = rd_ptr; the RAM latches mem[rd_ptr] at the edge ending this state; next state R_CAPTURE.
REQ-022 SHALL, in R_CAPTURE: keep cs_1 = oe_1 = 1 and address_1 unchanged (RAM output enable held); at the edge ending this state, m_data <= data_1, m_valid <= 1, rd_ptr wraps-increments, level decrements; next state R_IDLE.
REQ-023 SHALL drive cs_1 = oe_1 = 0 and address_1 = rd_ptr in R_IDLE.
REQ-024 SHALL clear m_valid on m_valid && m_ready at an edge; m_data holds its value until the next capture.
REQ-025 SHALL keep m_valid and m_data stable while m_valid && !m_ready.
REQ-026 SHALL update level: +1 on an accepted write; -1 on an R_CAPTURE exit; unchanged when both occur on the same edge.
REQ-027 SHALL drive full = (level == DEPTH), which protects the slot at rd_ptr until it is captured.
REQ-028 SHALL drive empty = (level == 0) && !m_valid.
REQ-029 SHALL produce, from an empty block, m_valid = 1 exactly 3 edges after the accept edge.
REQ-030 SHALL sustain a read throughput of one word per 4 cycles when m_ready = 1 continuously.
REQ-031 SHALL never overwrite an address that has not yet been captured.
REQ-032 SHALL never drop or reorder data: the output order equals the accept order.

Reset
REQ-033 SHALL, while rst_n = 0, asynchronously force: wr_ptr = rd_ptr = 0, level = 0, state R_IDLE, m_valid = 0, m_data = 0.
REQ-034 SHALL, while rst_n = 0, hold cs_0, we_0, cs_1 and oe_1 at 0, and s_ready at 0.
REQ-035 SHALL, on reset asserted mid-operation (any FSM state), abort any in-flight fetch and discard all held data.
REQ-036 SHALL, one cycle after rst_n deasserts, drive s_ready = 1, empty = 1, full = 0.

Verification
REQ-037 SHALL cover: rst_n pulsed low mid-R_CAPTURE -> all outputs 0 immediately; after release empty = 1, level = 0, and no stale m_valid.
REQ-038 SHALL cover: write 0xA5 into the empty block with m_ready = 1 -> cs_0 = we_0 = 1 with address_0 = 0 on the accept cycle; m_valid = 1 and m_data = 0xA5 three edges later; empty = 1 after the pop.
REQ-039 SHALL cover: m_ready = 0 while writing 0x00..0xFF, then 0x100 truncated to 0x00 -> 257 accepts; after the last accept full = 1, s_ready = 0, level = 256, m_data = 0x00.
REQ-040 SHALL cover: from the full state, pop once -> within 3 cycles level = 255, s_ready = 1, and the next m_data = 0x01.
REQ-041 SHALL cover: a write and an R_CAPTURE exit on the same edge with level = 5 -> level stays 5.
REQ-042 SHALL cover: 1024 words with random s_valid/m_ready (pointer wrap exercised 4x) -> scoreboard match and no assertion of cs_0 with we_0 = 0.

Source files
------------

// File: rtl/ram_dp_fifo_ctrl.sv
// Stream FIFO controller in front of a dual-port RAM.
// Port 0 writes on accept; port 1 reads via a fetch/capture FSM.
module ram_dp_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] address_0,
    output logic                  cs_0,
    output logic                  we_0,
    output logic                  oe_0,
    output logic [DATA_WIDTH-1:0] wdata_0,
    output logic [ADDR_WIDTH-1:0] address_1,
    output logic                  cs_1,
    output logic                  we_1,
    output logic                  oe_1,
    input  logic [DATA_WIDTH-1:0] data_1
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_CAPTURE
    } rd_state_t;

    rd_state_t             state;
    rd_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_en;
    logic                  cap;

    // The slot at rd_ptr stays counted in level until captured,
    // so full also blocks writes over a word still being fetched.
    assign full    = (level == DEPTH);
    assign empty   = (level == '0) && !m_valid;
    assign s_ready = rst_n && !full;
    assign wr_en   = s_valid && s_ready;

    assign cs_0      = wr_en;
    assign we_0      = wr_en;
    assign oe_0      = 1'b0;
    assign address_0 = wr_ptr;
    assign wdata_0   = s_data;

    assign we_1      = 1'b0;
    assign address_1 = rd_ptr;

    always_comb begin
        state_nxt = state;
        cs_1      = 1'b0;
        oe_1      = 1'b0;
        cap       = 1'b0;
        unique case (state)
            R_IDLE: begin
                if (level != '0 && !m_valid)
                    state_nxt = R_FETCH;
            end
            R_FETCH: begin
                cs_1      = 1'b1;
                oe_1      = 1'b1;
                state_nxt = R_CAPTURE;
            end
            R_CAPTURE: begin
                cs_1      = 1'b1;
                oe_1      = 1'b1;
                cap       = 1'b1;
                state_nxt = R_IDLE;
            end
            default: state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= R_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            state <= state_nxt;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (cap)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !cap)
                level <= level + 1'b1;
            else if (cap && !wr_en)
                level <= level - 1'b1;
            if (cap) begin
                m_data  <= data_1;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_dp_fifo_ctrl.sv
// Directed and random bench for ram_dp_fifo_ctrl with a RAM model
// and an accept-order scoreboard.
module tb_ram_dp_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [8:0] level;
    logic       full;
    logic       empty;
    logic [7:0] address_0;
    logic       cs_0;
    logic       we_0;
    logic       oe_0;
    logic [7:0] wdata_0;
    logic [7:0] address_1;
    logic       cs_1;
    logic       we_1;
    logic       oe_1;
    logic [7:0] data_1;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    logic [7:0] q[$];
    logic [7:0] mem[256];
    logic [7:0] rd_q;

    ram_dp_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .full(full), .empty(empty),
        .address_0(address_0), .cs_0(cs_0), .we_0(we_0),
        .oe_0(oe_0), .wdata_0(wdata_0),
        .address_1(address_1), .cs_1(cs_1), .we_1(we_1),
        .oe_1(oe_1), .data_1(data_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: port 1 latches on the fetch edge and
    // drives the latched word while output-enabled.
    always @(posedge clk) begin
        if (cs_0 && we_0)
            mem[address_0] <= wdata_0;
        if (cs_1 && oe_1)
            rd_q <= mem[address_1];
    end
    assign data_1 = (cs_1 && oe_1) ? rd_q : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Just before each rising edge: record accepts, check pops.
    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            chk("cs0_eq_we0", {31'd0, cs_0}, {31'd0, we_0});
            chk("oe0_we1_low", {30'd0, oe_0, we_1}, 32'd0);
            if (s_valid && s_ready) begin
                q.push_back(s_data);
                acc_cnt++;
            end
            if (m_valid && m_ready) begin
                pop_cnt++;
                tests++;
                assert (q.size() != 0) else begin
                    fails++;
                    $error("FAIL pop_underflow observed=%0h expected=queued",
                           m_data);
                end
                if (q.size() != 0)
                    chk("pop_data", {24'd0, m_data}, {24'd0, q.pop_front()});
            end
        end
    end

    initial begin
        int base_acc;
        int base_pop;
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h3C;
        m_ready = 1'b0;
        tick();
        tick();
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_cs0_we0", {30'd0, cs_0, we_0}, 32'd0);
        chk("rst_cs1_oe1", {30'd0, cs_1, oe_1}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_level", {23'd0, level}, 32'd0);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        tick();
        chk("rel_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rel_empty", {31'd0, empty}, 32'd1);
        chk("rel_full", {31'd0, full}, 32'd0);

        // Single word latency.
        m_ready = 1'b1;
        s_data  = 8'hA5;
        s_valid = 1'b1;
        #1;
        chk("acc_cs0_we0", {30'd0, cs_0, we_0}, 32'd3);
        chk("acc_addr0", {24'd0, address_0}, 32'd0);
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        chk("lat_no_early_valid", {31'd0, m_valid}, 32'd0);
        tick();
        chk("lat_m_valid", {31'd0, m_valid}, 32'd1);
        chk("lat_m_data", {24'd0, m_data}, 32'hA5);
        tick();
        chk("lat_empty_after_pop", {31'd0, empty}, 32'd1);

        // Fill to 257 accepts with no consumer.
        m_ready  = 1'b0;
        base_acc = acc_cnt;
        for (int i = 0; i <= 256; i++) begin
            s_data  = i[7:0];
            s_valid = 1'b1;
            tick();
        end
        #1;
        chk("full_blocks_cs0", {31'd0, cs_0}, 32'd0);
        s_valid = 1'b0;
        chk("fill_accepts", acc_cnt - base_acc, 32'd257);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_s_ready", {31'd0, s_ready}, 32'd0);
        chk("fill_level", {23'd0, level}, 32'd256);
        chk("fill_m_data", {24'd0, m_data}, 32'h00);
        chk("fill_m_valid", {31'd0, m_valid}, 32'd1);

        // One pop from full.
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        tick();
        tick();
        chk("pop1_level_hold", {23'd0, level}, 32'd256);
        tick();
        chk("pop1_level", {23'd0, level}, 32'd255);
        chk("pop1_s_ready", {31'd0, s_ready}, 32'd1);
        chk("pop1_m_valid", {31'd0, m_valid}, 32'd1);
        chk("pop1_m_data", {24'd0, m_data}, 32'h01);

        m_ready = 1'b1;
        for (int n = 0; n < 2000 && !(empty && q.size() == 0); n++)
            tick();
        chk("drain1_empty", {31'd0, empty}, 32'd1);
        chk("drain1_q", q.size(), 32'd0);

        // Write coinciding with a capture at level 5.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_data  = 8'h10 + i[7:0];
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        repeat (6) tick();
        chk("co_level_pre", {23'd0, level}, 32'd5);
        chk("co_m_data", {24'd0, m_data}, 32'h10);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        for (int n = 0; n < 10 && !cs_1; n++)
            tick();
        chk("co_fetch_seen", {31'd0, cs_1}, 32'd1);
        tick();
        chk("co_level_capture", {23'd0, level}, 32'd5);
        s_data  = 8'h77;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("co_level_post", {23'd0, level}, 32'd5);
        chk("co_m_data2", {24'd0, m_data}, 32'h11);
        m_ready = 1'b1;
        for (int n = 0; n < 200 && !(empty && q.size() == 0); n++)
            tick();
        chk("drain2_empty", {31'd0, empty}, 32'd1);

        // Reset in the middle of a capture.
        m_ready = 1'b0;
        s_data  = 8'h5A;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int n = 0; n < 10 && !cs_1; n++)
            tick();
        chk("mr_fetch_seen", {31'd0, cs_1}, 32'd1);
        tick();
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mr_cs1_oe1", {30'd0, cs_1, oe_1}, 32'd0);
        chk("mr_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mr_level", {23'd0, level}, 32'd0);
        chk("mr_s_ready", {31'd0, s_ready}, 32'd0);
        chk("mr_m_data", {24'd0, m_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_rel_empty", {31'd0, empty}, 32'd1);
        chk("mr_rel_level", {23'd0, level}, 32'd0);
        repeat (5) tick();
        chk("mr_no_stale_valid", {31'd0, m_valid}, 32'd0);

        // Random traffic, 1024 words.
        base_acc = acc_cnt;
        base_pop = pop_cnt;
        for (int n = 0; n < 30000 && (acc_cnt - base_acc) < 1024; n++) begin
            s_valid = ((acc_cnt - base_acc) < 1024) && ($urandom_range(0, 1) == 1);
            s_data  = 8'($urandom);
            m_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        s_valid = 1'b0;
        chk("rnd_accepts", acc_cnt - base_acc, 32'd1024);
        m_ready = 1'b1;
        for (int n = 0; n < 3000 && (pop_cnt - base_pop) < 1024; n++)
            tick();
        tick();
        chk("rnd_pops", pop_cnt - base_pop, 32'd1024);
        chk("rnd_q_empty", q.size(), 32'd0);
        chk("rnd_empty", {31'd0, empty}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
